// File: rtl/zq_video_pkg.sv
// Shared constants for the video dither output stage: widths, sync idle levels
// and the 4x4 Bayer threshold matrix.
package zq_video_pkg;

    localparam int IN_W_DEF  = 8;
    localparam int OUT_W_DEF = 4;

    localparam logic SYNC_IDLE = 1'b1;
    localparam logic DE_IDLE   = 1'b0;
    localparam logic BLANK_IDLE = 1'b0;

    localparam logic [3:0] BAYER [4][4] = '{
        '{4'd0,  4'd8,  4'd2,  4'd10},
        '{4'd12, 4'd4,  4'd14, 4'd6 },
        '{4'd3,  4'd11, 4'd1,  4'd9 },
        '{4'd15, 4'd7,  4'd13, 4'd5 }
    };

    function automatic logic [3:0] bayer_thr(input logic [1:0] y, input logic [1:0] x);
        return BAYER[y][x];
    endfunction

endpackage

// File: rtl/zq_dither_ch.sv
// One colour channel of the second pipeline stage: threshold add, saturate,
// truncate to pin width and force to zero outside the active area.
module zq_dither_ch
    import zq_video_pkg::*;
#(
    parameter int P_IN_W  = IN_W_DEF,
    parameter int P_OUT_W = OUT_W_DEF
) (
    input  logic               clk_v,
    input  logic               rst,
    input  logic [P_IN_W-1:0]  c,
    input  logic [3:0]         thr,
    input  logic               dither_en,
    input  logic               de,
    output logic [P_OUT_W-1:0] o_c
);

    logic [P_IN_W:0]    sum_next;
    logic [P_IN_W-1:0]  sat_next;
    logic [P_OUT_W-1:0] out_next;
    logic [P_OUT_W-1:0] out_reg;

    always_comb begin
        sum_next = {1'b0, c} + {{(P_IN_W - 3){1'b0}}, (dither_en ? thr : 4'd0)};
        // Carry out means the channel overflowed; clamp rather than wrap.
        sat_next = sum_next[P_IN_W] ? {P_IN_W{1'b1}} : sum_next[P_IN_W-1:0];
        out_next = de ? sat_next[P_IN_W-1 -: P_OUT_W] : '0;
    end

    always_ff @(posedge clk_v) begin
        if (rst) begin
            out_reg <= '0;
        end else begin
            out_reg <= out_next;
        end
    end

    assign o_c = out_reg;

endmodule

// File: rtl/zq_video_dither_out.sv
// VGA pin driver: registers video, derives Bayer position counters and dithers
// 8-bit RGB down to 4-bit pins with a fixed two-cycle latency.
module zq_video_dither_out
    import zq_video_pkg::*;
#(
    parameter int P_IN_W     = IN_W_DEF,
    parameter int P_OUT_W    = OUT_W_DEF,
    parameter int P_TEMPORAL = 1
) (
    input  logic               clk_v,
    input  logic               rst,
    input  logic               i_dither_en,
    input  logic               i_blank_x,
    input  logic               i_hsync_x,
    input  logic               i_vsync_x,
    input  logic [P_IN_W-1:0]  i_vr,
    input  logic [P_IN_W-1:0]  i_vg,
    input  logic [P_IN_W-1:0]  i_vb,
    output logic               o_de,
    output logic               o_hsync_x,
    output logic               o_vsync_x,
    output logic [P_OUT_W-1:0] o_vr,
    output logic [P_OUT_W-1:0] o_vg,
    output logic [P_OUT_W-1:0] o_vb
);

    logic [2:0][P_IN_W-1:0]  color_in;
    logic [2:0][P_IN_W-1:0]  color_reg;
    logic [2:0][P_OUT_W-1:0] color_out;

    logic       blank_reg, hsync_reg, vsync_reg, dither_en_reg;
    logic [3:0] thr_reg;
    logic [1:0] xq_reg, yq_reg, frame_reg;
    logic       de_out_reg, hsync_out_reg, vsync_out_reg;

    logic       blank_fall, vsync_fall;
    logic [1:0] fq;
    logic [1:0] xq_next, yq_next, frame_next;
    logic [3:0] thr_next;

    assign color_in = {i_vb, i_vg, i_vr};

    always_comb begin
        blank_fall = blank_reg & ~i_blank_x;
        vsync_fall = vsync_reg & ~i_vsync_x;
        fq         = (P_TEMPORAL != 0) ? frame_reg : 2'd0;
        thr_next   = bayer_thr(yq_reg, xq_reg ^ fq);

        xq_next    = i_blank_x ? xq_reg + 2'd1 : 2'd0;
        frame_next = vsync_fall ? frame_reg + 2'd1 : frame_reg;
        // A vsync edge landing on the end of a line must leave the row at zero.
        if (vsync_fall) begin
            yq_next = 2'd0;
        end else if (blank_fall) begin
            yq_next = yq_reg + 2'd1;
        end else begin
            yq_next = yq_reg;
        end
    end

    always_ff @(posedge clk_v) begin
        if (rst) begin
            color_reg     <= '0;
            blank_reg     <= BLANK_IDLE;
            hsync_reg     <= SYNC_IDLE;
            vsync_reg     <= SYNC_IDLE;
            dither_en_reg <= 1'b0;
            thr_reg       <= '0;
            xq_reg        <= '0;
            yq_reg        <= '0;
            frame_reg     <= '0;
            de_out_reg    <= DE_IDLE;
            hsync_out_reg <= SYNC_IDLE;
            vsync_out_reg <= SYNC_IDLE;
        end else begin
            color_reg     <= color_in;
            blank_reg     <= i_blank_x;
            hsync_reg     <= i_hsync_x;
            vsync_reg     <= i_vsync_x;
            dither_en_reg <= i_dither_en;
            thr_reg       <= thr_next;
            xq_reg        <= xq_next;
            yq_reg        <= yq_next;
            frame_reg     <= frame_next;
            de_out_reg    <= blank_reg;
            hsync_out_reg <= hsync_reg;
            vsync_out_reg <= vsync_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_ch
            zq_dither_ch #(
                .P_IN_W  (P_IN_W),
                .P_OUT_W (P_OUT_W)
            ) u_ch (
                .clk_v     (clk_v),
                .rst       (rst),
                .c         (color_reg[gi]),
                .thr       (thr_reg),
                .dither_en (dither_en_reg),
                .de        (blank_reg),
                .o_c       (color_out[gi])
            );
        end
    endgenerate

    assign o_de      = de_out_reg;
    assign o_hsync_x = hsync_out_reg;
    assign o_vsync_x = vsync_out_reg;
    assign o_vr      = color_out[0];
    assign o_vg      = color_out[1];
    assign o_vb      = color_out[2];

endmodule

// File: tb/tb_zq_video_dither_out.sv
// Directed checks of latency, Bayer dithering, saturation, blanking,
// temporal pattern rotation and mid-line reset.
module tb_zq_video_dither_out;

    logic       clk_v = 1'b0;
    logic       rst;
    logic       i_dither_en, i_blank_x, i_hsync_x, i_vsync_x;
    logic [7:0] i_vr, i_vg, i_vb;
    logic       o_de, o_hsync_x, o_vsync_x;
    logic [3:0] o_vr, o_vg, o_vb;

    int n_cmp  = 0;
    int n_fail = 0;

    zq_video_dither_out #(
        .P_IN_W     (8),
        .P_OUT_W    (4),
        .P_TEMPORAL (1)
    ) dut (
        .clk_v       (clk_v),
        .rst         (rst),
        .i_dither_en (i_dither_en),
        .i_blank_x   (i_blank_x),
        .i_hsync_x   (i_hsync_x),
        .i_vsync_x   (i_vsync_x),
        .i_vr        (i_vr),
        .i_vg        (i_vg),
        .i_vb        (i_vb),
        .o_de        (o_de),
        .o_hsync_x   (o_hsync_x),
        .o_vsync_x   (o_vsync_x),
        .o_vr        (o_vr),
        .o_vg        (o_vg),
        .o_vb        (o_vb)
    );

    always #5 clk_v = ~clk_v;

    task automatic tick();
        @(posedge clk_v);
        #1;
    endtask

    task automatic drive(input logic blank, input logic hs, input logic vs,
                         input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                         input logic den);
        i_blank_x   = blank;
        i_hsync_x   = hs;
        i_vsync_x   = vs;
        i_vr        = r;
        i_vg        = g;
        i_vb        = b;
        i_dither_en = den;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF, 1'b1);
        tick();
        tick();
        tick();
        n_cmp++; if (o_de !== 1'b0) begin n_fail++; $display("FAIL reset_de: got %b want 0", o_de); end
        n_cmp++; if (o_hsync_x !== 1'b1) begin n_fail++; $display("FAIL reset_hsync: got %b want 1", o_hsync_x); end
        n_cmp++; if (o_vsync_x !== 1'b1) begin n_fail++; $display("FAIL reset_vsync: got %b want 1", o_vsync_x); end
        n_cmp++; if ({o_vr, o_vg, o_vb} !== 12'h000) begin n_fail++; $display("FAIL reset_rgb: got %h want 000", {o_vr, o_vg, o_vb}); end
        rst = 1'b0;
        $display("reset: de=%b hs=%b vs=%b rgb=%h", o_de, o_hsync_x, o_vsync_x, {o_vr, o_vg, o_vb});
    endtask

    task automatic test_latency();
        do_reset();
        tick();
        drive(1'b1, 1'b0, 1'b1, 8'h87, 8'h00, 8'h00, 1'b0);
        tick();
        n_cmp++; if (o_hsync_x !== 1'b1) begin n_fail++; $display("FAIL latency_hs_early: got %b want 1", o_hsync_x); end
        n_cmp++; if (o_de !== 1'b0) begin n_fail++; $display("FAIL latency_de_early: got %b want 0", o_de); end
        drive(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
        tick();
        n_cmp++; if (o_hsync_x !== 1'b0) begin n_fail++; $display("FAIL latency_hs: got %b want 0", o_hsync_x); end
        n_cmp++; if (o_de !== 1'b1) begin n_fail++; $display("FAIL latency_de: got %b want 1", o_de); end
        n_cmp++; if (o_vr !== 4'h8) begin n_fail++; $display("FAIL latency_vr: got %h want 8", o_vr); end
        $display("latency: hs=%b de=%b vr=%h", o_hsync_x, o_de, o_vr);
        tick();
        n_cmp++; if (o_hsync_x !== 1'b1) begin n_fail++; $display("FAIL latency_hs_rise: got %b want 1", o_hsync_x); end
    endtask

    task automatic test_dither_row0();
        logic [3:0] exp_r [4] = '{4'h8, 4'h8, 4'h8, 4'h9};
        logic [3:0] exp_g [4] = '{4'h7, 4'h8, 4'h8, 4'h8};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive(1'b1, 1'b1, 1'b1, 8'h87, 8'h7E, 8'h00, 1'b1);
            else       drive(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b1);
            tick();
            if (i >= 1) begin
                n_cmp++; if (o_vr !== exp_r[i-1]) begin n_fail++; $display("FAIL row0_vr x=%0d: got %h want %h", i-1, o_vr, exp_r[i-1]); end
                n_cmp++; if (o_vg !== exp_g[i-1]) begin n_fail++; $display("FAIL row0_vg x=%0d: got %h want %h", i-1, o_vg, exp_g[i-1]); end
                $display("row0 x=%0d: vr=%h vg=%h", i-1, o_vr, o_vg);
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int l = 0; l < 3; l++) begin
            drive(1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b1);
            tick();
            drive(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b1);
            tick();
        end
        drive(1'b1, 1'b1, 1'b1, 8'h71, 8'hFF, 8'h00, 1'b1);
        tick();
        drive(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b1);
        tick();
        n_cmp++; if (o_vg !== 4'hF) begin n_fail++; $display("FAIL sat_vg: got %h want f", o_vg); end
        n_cmp++; if (o_vr !== 4'h8) begin n_fail++; $display("FAIL sat_row3_vr: got %h want 8", o_vr); end
        $display("saturation: vg=%h vr=%h", o_vg, o_vr);
    endtask

    task automatic test_blanking();
        do_reset();
        drive(1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'h10, 1'b1);
        tick();
        tick();
        drive(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'hFF, 1'b1);
        tick();
        drive(1'b1, 1'b1, 1'b1, 8'h72, 8'h00, 8'h00, 1'b1);
        tick();
        n_cmp++; if (o_vb !== 4'h0) begin n_fail++; $display("FAIL blank_vb: got %h want 0", o_vb); end
        n_cmp++; if (o_de !== 1'b0) begin n_fail++; $display("FAIL blank_de: got %b want 0", o_de); end
        $display("blanking: vb=%h de=%b", o_vb, o_de);
        drive(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b1);
        tick();
        n_cmp++; if (o_vr !== 4'h7) begin n_fail++; $display("FAIL blank_next_col0: got %h want 7", o_vr); end
        n_cmp++; if (o_de !== 1'b1) begin n_fail++; $display("FAIL blank_next_de: got %b want 1", o_de); end
        $display("after blank: vr=%h de=%b", o_vr, o_de);
    endtask

    task automatic test_temporal();
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
        tick();
        drive(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b1);
        tick();
        n_cmp++; if (o_vsync_x !== 1'b0) begin n_fail++; $display("FAIL temporal_vsync: got %b want 0", o_vsync_x); end
        drive(1'b1, 1'b1, 1'b1, 8'h7E, 8'h00, 8'h00, 1'b1);
        tick();
        tick();
        n_cmp++; if (o_vr !== 4'h8) begin n_fail++; $display("FAIL temporal_f1_x0: got %h want 8", o_vr); end
        drive(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b1);
        tick();
        n_cmp++; if (o_vr !== 4'h7) begin n_fail++; $display("FAIL temporal_f1_x1: got %h want 7", o_vr); end
        $display("temporal frame1: vr=%h", o_vr);
        drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
        tick();
        drive(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b1);
        tick();
        drive(1'b1, 1'b1, 1'b1, 8'h7E, 8'h00, 8'h00, 1'b1);
        tick();
        drive(1'b1, 1'b1, 1'b1, 8'h76, 8'h00, 8'h00, 1'b1);
        tick();
        n_cmp++; if (o_vr !== 4'h8) begin n_fail++; $display("FAIL temporal_f2_x0: got %h want 8", o_vr); end
        drive(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b1);
        tick();
        n_cmp++; if (o_vr !== 4'h8) begin n_fail++; $display("FAIL temporal_f2_x1: got %h want 8", o_vr); end
        $display("temporal frame2: vr=%h", o_vr);
    endtask

    task automatic test_reset_midline();
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 8'h7E, 8'h00, 8'h00, 1'b1);
        tick();
        tick();
        tick();
        n_cmp++; if (o_hsync_x !== 1'b0) begin n_fail++; $display("FAIL midrst_pre_hs: got %b want 0", o_hsync_x); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (o_de !== 1'b0) begin n_fail++; $display("FAIL midrst_de: got %b want 0", o_de); end
        n_cmp++; if (o_hsync_x !== 1'b1) begin n_fail++; $display("FAIL midrst_hs: got %b want 1", o_hsync_x); end
        n_cmp++; if ({o_vr, o_vg, o_vb} !== 12'h000) begin n_fail++; $display("FAIL midrst_rgb: got %h want 000", {o_vr, o_vg, o_vb}); end
        drive(1'b1, 1'b1, 1'b1, 8'h7E, 8'h00, 8'h00, 1'b1);
        tick();
        drive(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b1);
        tick();
        n_cmp++; if (o_vr !== 4'h7) begin n_fail++; $display("FAIL midrst_first_px: got %h want 7", o_vr); end
        n_cmp++; if (o_de !== 1'b1) begin n_fail++; $display("FAIL midrst_first_de: got %b want 1", o_de); end
        $display("reset mid-line: first vr=%h de=%b", o_vr, o_de);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
        test_reset();
        test_latency();
        test_dither_row0();
        test_saturation();
        test_blanking();
        test_temporal();
        test_reset_midline();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
